// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - opcode map, FSM states and decode helper for alu_exec_unit
package alu_exec_pkg;

  localparam int unsigned OP_ADD    = 0;
  localparam int unsigned OP_SUB    = 1;
  localparam int unsigned OP_SLL    = 2;
  localparam int unsigned OP_SLT    = 3;
  localparam int unsigned OP_SLTU   = 4;
  localparam int unsigned OP_XOR    = 5;
  localparam int unsigned OP_SRL    = 6;
  localparam int unsigned OP_SRA    = 7;
  localparam int unsigned OP_OR     = 8;
  localparam int unsigned OP_AND    = 9;
  localparam int unsigned OP_PASSB  = 10;

  localparam int unsigned OP_MUL    = 16;
  localparam int unsigned OP_MULH   = 17;
  localparam int unsigned OP_MULHSU = 18;
  localparam int unsigned OP_MULHU  = 19;
  localparam int unsigned OP_DIV    = 20;
  localparam int unsigned OP_DIVU   = 21;
  localparam int unsigned OP_REM    = 22;
  localparam int unsigned OP_REMU   = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for the RV32M codes; the low three bits then select the M sub-op.
  function automatic logic is_mdu_op(input int unsigned code);
    return (code >= OP_MUL) && (code <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_exec_unit_mdu_iter.sv
// rtl/alu_exec_unit_mdu_iter.sv - iterative shift-add multiplier / restoring divider
module mdu_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  step,
  input  logic [2:0]            sub_op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]   lo;
  logic [DATA_WIDTH-1:0]   b_mag;
  logic                    is_div;
  logic                    want_hi;
  logic                    want_rem;
  logic                    neg_res;

  logic                    is_div_in;
  logic                    a_signed;
  logic                    b_signed;
  logic                    a_neg;
  logic                    b_neg;
  logic [DATA_WIDTH-1:0]   a_mag_in;
  logic [DATA_WIDTH-1:0]   b_mag_in;
  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH:0]     div_shift;
  logic [DATA_WIDTH:0]     div_diff;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0]   div_val;

  // Operand signedness per sub-op, then magnitudes so the core loop is unsigned.
  always_comb begin
    is_div_in = sub_op[2];
    a_signed  = is_div_in ? !sub_op[0] : (sub_op[1:0] != 2'd3);
    b_signed  = is_div_in ? !sub_op[0] : !sub_op[1];
    a_neg     = a_signed && op_a[DATA_WIDTH-1];
    b_neg     = b_signed && op_b[DATA_WIDTH-1];
    a_mag_in  = a_neg ? -op_a : op_a;
    b_mag_in  = b_neg ? -op_b : op_b;
  end

  // One iteration's worth of datapath: add-and-shift for mul, trial subtract for div.
  always_comb begin
    mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, b_mag} : '0);
    div_shift = {acc, lo[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag};
  end

  // Operand latch at start, one step per cycle while stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      lo       <= '0;
      b_mag    <= '0;
      is_div   <= 1'b0;
      want_hi  <= 1'b0;
      want_rem <= 1'b0;
      neg_res  <= 1'b0;
    end else if (start) begin
      cnt      <= CW'(DATA_WIDTH - 1);
      acc      <= '0;
      lo       <= a_mag_in;
      b_mag    <= b_mag_in;
      is_div   <= is_div_in;
      want_hi  <= (sub_op[1:0] != 2'd0);
      want_rem <= sub_op[1];
      // Remainder takes the dividend's sign; quotient and product the xor.
      neg_res  <= (is_div_in && sub_op[1]) ? a_neg : (a_neg ^ b_neg);
    end else if (step) begin
      cnt <= cnt - CW'(1);
      if (is_div) begin
        if (!div_diff[DATA_WIDTH]) begin
          acc <= div_diff[DATA_WIDTH-1:0];
          lo  <= {lo[DATA_WIDTH-2:0], 1'b1};
        end else begin
          acc <= div_shift[DATA_WIDTH-1:0];
          lo  <= {lo[DATA_WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= mul_sum[DATA_WIDTH:1];
        lo  <= {mul_sum[0], lo[DATA_WIDTH-1:1]};
      end
    end
  end

  // Sign fix-up of the finished magnitudes and half/quotient/remainder select.
  always_comb begin
    prod     = {acc, lo};
    prod_fix = neg_res ? -prod : prod;
    div_val  = want_rem ? acc : lo;
    result   = '0;
    if (is_div) begin
      result = neg_res ? -div_val : div_val;
    end else begin
      result = want_hi ? prod_fix[2*DATA_WIDTH-1:DATA_WIDTH] : prod_fix[DATA_WIDTH-1:0];
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - registered, stallable RV32 execute stage with iterative M unit
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int FUNC_WIDTH = 5,
  parameter int MDU_ENABLE = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_WIDTH-1:0] PC_IN,
  input  logic [DATA_WIDTH-1:0] RS1_IN,
  input  logic [DATA_WIDTH-1:0] RS2_IN,
  input  logic [DATA_WIDTH-1:0] IMM_IN,
  input  logic [FUNC_WIDTH-1:0] ALU_CTRL,
  input  logic                  MUX1_CTRL,
  input  logic                  MUX2_CTRL,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] ALU_OUT,
  output logic                  BUSY
);

  import alu_exec_pkg::*;

  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] mdu_res;
  logic [SW-1:0]         shamt;
  int unsigned           op_code;
  logic                  accept;
  logic                  mdu_op;
  logic                  div_by_zero;
  logic                  div_ovf;
  logic                  mdu_special;
  logic                  start_calc;
  logic                  alu_wr;
  logic                  calc_step;
  logic                  mdu_done;

  assign op_a    = MUX1_CTRL ? PC_IN : RS1_IN;
  assign op_b    = MUX2_CTRL ? IMM_IN : RS2_IN;
  assign shamt   = op_b[SW-1:0];
  assign op_code = 32'(ALU_CTRL);

  assign IN_READY  = (state == ST_IDLE) && (!OUT_VALID || OUT_READY);
  assign BUSY      = (state == ST_CALC) || (state == ST_DONE);
  assign accept    = IN_VALID && IN_READY;
  assign calc_step = (state == ST_CALC);

  // Divide-by-zero and signed overflow are answered at accept, never iterated.
  assign div_by_zero = (op_b == '0);
  assign div_ovf     = (op_a == MIN_NEG) && (&op_b);
  assign mdu_special = ((op_code >= OP_DIV) && (op_code <= OP_REMU) && div_by_zero) ||
                       (((op_code == OP_DIV) || (op_code == OP_REM)) && div_ovf);
  assign mdu_op      = (MDU_ENABLE != 0) && is_mdu_op(op_code);
  assign start_calc  = accept && mdu_op && !mdu_special;
  assign alu_wr      = accept && !start_calc;

  // Single-cycle ALU, including the resolved-at-accept division corner cases.
  always_comb begin
    alu_res = '0;
    case (op_code)
      OP_ADD:   alu_res = op_a + op_b;
      OP_SUB:   alu_res = op_a - op_b;
      OP_SLL:   alu_res = op_a << shamt;
      OP_SLT:   alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU:  alu_res = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_SRL:   alu_res = op_a >> shamt;
      OP_SRA:   alu_res = $signed(op_a) >>> shamt;
      OP_OR:    alu_res = op_a | op_b;
      OP_AND:   alu_res = op_a & op_b;
      OP_PASSB: alu_res = op_b;
      OP_DIV, OP_DIVU: begin
        if ((MDU_ENABLE != 0) && div_by_zero) begin
          alu_res = '1;
        end else if ((MDU_ENABLE != 0) && (op_code == OP_DIV) && div_ovf) begin
          alu_res = op_a;
        end
      end
      OP_REM, OP_REMU: begin
        if ((MDU_ENABLE != 0) && div_by_zero) begin
          alu_res = op_a;
        end
      end
      default:  alu_res = '0;
    endcase
  end

  if (MDU_ENABLE != 0) begin : g_mdu
    mdu_iter #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_mdu (
      .clk    (CLK),
      .rst_n  (RST_N),
      .start  (start_calc),
      .step   (calc_step),
      .sub_op (op_code[2:0]),
      .op_a   (op_a),
      .op_b   (op_b),
      .done   (mdu_done),
      .result (mdu_res)
    );
  end else begin : g_no_mdu
    assign mdu_done = 1'b0;
    assign mdu_res  = '0;
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: IDLE -> CALC on an iterated M op, CALC -> DONE on the last step.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_calc) state_nxt = ST_CALC;
      ST_CALC: if (mdu_done) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output slot: a new result wins over consumption, otherwise hold until taken.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ALU_OUT   <= '0;
      OUT_VALID <= 1'b0;
    end else if (alu_wr) begin
      ALU_OUT   <= alu_res;
      OUT_VALID <= 1'b1;
    end else if (state == ST_DONE) begin
      ALU_OUT   <= mdu_res;
      OUT_VALID <= 1'b1;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] pc_in = '0;
  logic [DW-1:0] rs1_in = '0;
  logic [DW-1:0] rs2_in = '0;
  logic [DW-1:0] imm_in = '0;
  logic [4:0]    alu_ctrl = '0;
  logic          mux1_ctrl = 1'b0;
  logic          mux2_ctrl = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] alu_out;
  logic          busy;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.DATA_WIDTH(DW), .FUNC_WIDTH(5), .MDU_ENABLE(1)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .PC_IN     (pc_in),
    .RS1_IN    (rs1_in),
    .RS2_IN    (rs2_in),
    .IMM_IN    (imm_in),
    .ALU_CTRL  (alu_ctrl),
    .MUX1_CTRL (mux1_ctrl),
    .MUX2_CTRL (mux2_ctrl),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .ALU_OUT   (alu_out),
    .BUSY      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pu;
    longint      ps;
    logic [4:0]  sh;
    logic [31:0] r;
    sh = b[4:0];
    r  = '0;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a << sh;
      3:  r = {31'b0, $signed(a) < $signed(b)};
      4:  r = {31'b0, a < b};
      5:  r = a ^ b;
      6:  r = a >> sh;
      7:  r = $signed(a) >>> sh;
      8:  r = a | b;
      9:  r = a & b;
      10: r = b;
      16: begin pu = {32'b0, a} * {32'b0, b}; r = pu[31:0]; end
      17: begin ps = longint'($signed(a)) * longint'($signed(b)); r = ps[63:32]; end
      18: begin ps = longint'($signed(a)) * longint'({32'b0, b}); r = ps[63:32]; end
      19: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
      20: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = $signed(a) / $signed(b);
      end
      21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      22: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = $signed(a) % $signed(b);
      end
      23: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // M ops that are not answered immediately take DW+1 edges.
  function automatic int model_edges(input int op, input logic [31:0] a, input logic [31:0] b);
    if (op < 16 || op > 23) return 0;
    if (op >= 20 && b == 0) return 0;
    if ((op == 20 || op == 22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return DW + 1;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input int op, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm,
                        input logic m1, input logic m2,
                        output logic [31:0] obs, output int edges);
    logic [31:0] a, b, exp;
    int exp_edges, n;
    bit busy_bad;
    a = m1 ? pc : rs1;
    b = m2 ? imm : rs2;
    exp = model(op, a, b);
    exp_edges = model_edges(op, a, b);
    @(negedge clk);
    pc_in = pc; rs1_in = rs1; rs2_in = rs2; imm_in = imm;
    mux1_ctrl = m1; mux2_ctrl = m2; alu_ctrl = op[4:0];
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout op=%0d: in_ready=%b, required 1", op, in_ready);
      in_valid = 1'b0; obs = '0; edges = -1;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 1; busy_bad = 0;
    while (!out_valid && n < 100) begin
      if (busy !== 1'b1) busy_bad = 1;
      @(negedge clk);
      n++;
    end
    edges = n - 1;
    obs = alu_out;
    checks++;
    if (edges !== exp_edges) begin
      errors++;
      $display("FAIL latency op=%0d a=%h b=%h: edges=%0d, required %0d", op, a, b, edges, exp_edges);
    end
    checks++;
    if (alu_out !== exp) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h: got %h, required %h", op, a, b, alu_out, exp);
    end
    if (exp_edges > 0) begin
      checks++;
      if (busy_bad) begin
        errors++;
        $display("FAIL busy_during_calc op=%0d: busy dropped, required 1 throughout", op);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || alu_out !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b out=%h ready=%b, required 0 0 00000000 1",
               out_valid, busy, alu_out, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_alu_directed();
    logic [31:0] obs;
    int e;
    run_op(0, 32'h100, 32'h0, 32'h0, 32'h4, 1'b1, 1'b1, obs, e);
    checks++;
    if (obs !== 32'h104) begin errors++; $display("FAIL add_pc_imm: got %h, required 00000104", obs); end
    run_op(7, 32'h0, 32'h8000_0000, 32'h0, 32'h21, 1'b0, 1'b1, obs, e);
    checks++;
    if (obs !== 32'hC000_0000) begin errors++; $display("FAIL sra_shamt_mask: got %h, required c0000000", obs); end
    run_op(12, 32'h0, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b0, obs, e);
    checks++;
    if (obs !== 32'h0) begin errors++; $display("FAIL undefined_code: got %h, required 00000000", obs); end
  endtask

  task automatic test_mdu_directed();
    logic [31:0] obs;
    int e;
    run_op(17, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, obs, e);
    checks++;
    if (obs !== 32'h0 || e !== 33) begin errors++; $display("FAIL mulh_m1: got %h/%0d, required 00000000/33", obs, e); end
    run_op(19, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, obs, e);
    checks++;
    if (obs !== 32'hFFFF_FFFE || e !== 33) begin errors++; $display("FAIL mulhu_m1: got %h/%0d, required fffffffe/33", obs, e); end
    run_op(20, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, obs, e);
    checks++;
    if (obs !== 32'h8000_0000 || e !== 0) begin errors++; $display("FAIL div_ovf: got %h/%0d, required 80000000/0", obs, e); end
    run_op(22, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, obs, e);
    checks++;
    if (obs !== 32'h0 || e !== 0) begin errors++; $display("FAIL rem_ovf: got %h/%0d, required 00000000/0", obs, e); end
    run_op(21, 0, 32'd7, 32'd0, 0, 1'b0, 1'b0, obs, e);
    checks++;
    if (obs !== 32'hFFFF_FFFF || e !== 0) begin errors++; $display("FAIL divu_by_zero: got %h/%0d, required ffffffff/0", obs, e); end
    run_op(23, 0, 32'd7, 32'd0, 0, 1'b0, 1'b0, obs, e);
    checks++;
    if (obs !== 32'd7 || e !== 0) begin errors++; $display("FAIL remu_by_zero: got %h/%0d, required 00000007/0", obs, e); end
    run_op(20, 0, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0, obs, e);
    checks++;
    if (obs !== 32'hFFFF_FFFD || e !== 33) begin errors++; $display("FAIL div_neg7_2: got %h/%0d, required fffffffd/33", obs, e); end
    run_op(22, 0, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0, obs, e);
    checks++;
    if (obs !== 32'hFFFF_FFFF || e !== 33) begin errors++; $display("FAIL rem_neg7_2: got %h/%0d, required ffffffff/33", obs, e); end
  endtask

  task automatic test_random_ops();
    int codes[21] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18, 19, 20, 21, 22, 23};
    logic [31:0] obs;
    int e;
    for (int i = 0; i < 60; i++) begin
      run_op(codes[$urandom_range(0, 20)], rnd_val(), rnd_val(), rnd_val(), rnd_val(),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), obs, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, exp;
    int op;
    @(negedge clk);
    pc_in = 32'h100; imm_in = 32'h4; mux1_ctrl = 1'b1; mux2_ctrl = 1'b1;
    alu_ctrl = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || alu_out !== 32'h104 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_add beat %0d: valid=%b ready=%b out=%h, required 1 1 00000104",
                 i, out_valid, in_ready, alu_out);
      end
    end
    for (int i = 0; i < 12; i++) begin
      op = $urandom_range(0, 10);
      pc_in = rnd_val(); rs1_in = rnd_val(); rs2_in = rnd_val(); imm_in = rnd_val();
      mux1_ctrl = 1'($urandom_range(0, 1)); mux2_ctrl = 1'($urandom_range(0, 1));
      alu_ctrl = op[4:0];
      a = mux1_ctrl ? pc_in : rs1_in;
      b = mux2_ctrl ? imm_in : rs2_in;
      exp = model(op, a, b);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || alu_out !== exp) begin
        errors++;
        $display("FAIL b2b_random op=%0d: valid=%b out=%h, required 1 %h", op, out_valid, alu_out, exp);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: valid=%b, required 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp1, exp2;
    @(negedge clk);
    rs1_in = $urandom; rs2_in = $urandom; mux1_ctrl = 1'b0; mux2_ctrl = 1'b0;
    alu_ctrl = 5'd0; in_valid = 1'b1; out_ready = 1'b0;
    exp1 = rs1_in + rs2_in;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || alu_out !== exp1) begin
      errors++;
      $display("FAIL bp_first: valid=%b out=%h, required 1 %h", out_valid, alu_out, exp1);
    end
    rs1_in = $urandom; rs2_in = $urandom | 32'h1; alu_ctrl = 5'd1;
    exp2 = rs1_in - rs2_in;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || alu_out !== exp1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b out=%h ready=%b, required 1 %h 0",
                 i, out_valid, alu_out, in_ready, exp1);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: ready=%b, required 1", in_ready); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || alu_out !== exp2) begin
      errors++;
      $display("FAIL bp_replace: valid=%b out=%h, required 1 %h", out_valid, alu_out, exp2);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_clear: valid=%b, required 0", out_valid); end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    @(negedge clk);
    rs1_in = $urandom | 32'h1; rs2_in = $urandom | 32'h1; mux1_ctrl = 1'b0; mux2_ctrl = 1'b0;
    alu_ctrl = 5'd16; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: busy=%b, required 1", busy); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || alu_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_async: valid=%b busy=%b out=%h, required 0 0 00000000", out_valid, busy, alu_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_release: ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_mid_no_result: stale result appeared, required none"); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_directed();
    test_mdu_directed();
    test_back_to_back();
    test_backpressure();
    test_random_ops();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised execute stage for the RV32 core. It contains the PC/RS1 and RS2/IMM operand selection, a single-cycle integer ALU, and an iterative RV32M multiply/divide unit, all behind a valid/ready handshake. It sits between decode/issue and writeback. It replaces the purely combinational ALU top with a registered, stallable result.

Parameters:
DATA_WIDTH, 32, operand and result width (power of two, >= 8)
FUNC_WIDTH, 5, width of ALU_CTRL
MDU_ENABLE, 1, 1 = M-extension ops implemented; 0 = M codes return 0 with ALU latency

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
PC_IN  in  DATA_WIDTH  program counter operand
RS1_IN  in  DATA_WIDTH  register source 1
RS2_IN  in  DATA_WIDTH  register source 2
IMM_IN  in  DATA_WIDTH  immediate
ALU_CTRL  in  FUNC_WIDTH  operation code (package encoding)
MUX1_CTRL  in  1  A select: 1 = PC_IN, 0 = RS1_IN
MUX2_CTRL  in  1  B select: 1 = IMM_IN, 0 = RS2_IN
IN_VALID  in  1  operation presented
IN_READY  out  1  unit can accept an operation this cycle
OUT_VALID  out  1  ALU_OUT holds a result
OUT_READY  in  1  consumer takes the result
ALU_OUT  out  DATA_WIDTH  registered result
BUSY  out  1  iterative M operation in progress

Behaviour:
- Reset (async assert, sync release): state IDLE, ALU_OUT = 0, OUT_VALID = 0, BUSY = 0, counters and operand registers = 0.
- Any RST_N low, including mid-iteration, aborts the operation with no result.
- Accept occurs when IN_VALID && IN_READY at a rising edge. A/B are selected and latched at the accept edge. Inputs are don't-care at all other times.
- IN_READY = (state == IDLE) && (!OUT_VALID || OUT_READY). This is combinational and gives back-to-back single-cycle throughput.
- ALU ops: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10. The result is registered at the accept edge (latency 1). Shifts use B[log2(DATA_WIDTH)-1:0]. SLT/SLTU return 0 or 1, zero-extended. Undefined codes return 0.
- M ops: MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23.
- FSM IDLE -> CALC at accept of an M op (BUSY=1). Counter is loaded with DATA_WIDTH-1.
- CALC performs one shift-add (mul) or one restoring step (div) per cycle. It does this on magnitudes, with sign fix-up at the end.
- CALC -> DONE when the counter reaches 0. DONE writes ALU_OUT and sets OUT_VALID, then goes to IDLE.
- OUT_VALID rises exactly DATA_WIDTH+1 edges after the accepting edge.
- MUL returns the low half of the product. MULH/MULHSU/MULHU return the high half of the 2*DATA_WIDTH product. MULHSU treats A as signed and B as unsigned.
- Divide by zero: resolved at accept with latency 1, no CALC. DIV/DIVU return all ones; REM/REMU return A.
- Signed overflow (A = most negative, B = -1): resolved at accept with latency 1. DIV returns A; REM returns 0.
- Output hold: while OUT_VALID && !OUT_READY, ALU_OUT and OUT_VALID are stable. An M op finishing in DONE with a pending unconsumed result cannot occur, because accept requires the output slot to be free.
- OUT_VALID clears on the OUT_READY edge unless a new ALU result is written on the same edge, in which case OUT_VALID stays 1 and ALU_OUT updates.
- MDU_ENABLE = 0: codes 16-23 behave as undefined (0, latency 1). No CALC logic is generated.

Decomposition:
- Package alu_exec_pkg holds the ALU_CTRL code localparams, the FSM state encoding (IDLE, CALC, DONE), and the is_mdu_op function.
- Sub-module mdu_iter is the iterative multiply/divide datapath: operand magnitude/sign latch, shift registers, counter, and done pulse.
- The top holds the operand muxes, the combinational ALU, the FSM and the output register.

Test Plan:
- Reset mid-op: issue MUL, assert RST_N=0 at cycle 5 -> OUT_VALID=0, BUSY=0 and ALU_OUT=0 immediately. IN_READY=1 after release.
- ADD with MUX1_CTRL=1, MUX2_CTRL=1, PC_IN=0x100, IMM_IN=0x4, OUT_READY=1, IN_VALID held 3 cycles -> 0x104 each cycle, no bubbles. SRA of 0x80000000 by B=0x21 -> 0xC0000000.
- MULH RS1=0xFFFFFFFF, RS2=0xFFFFFFFF -> 0x00000000. MULHU with the same operands -> 0xFFFFFFFE. OUT_VALID exactly 33 edges after accept; BUSY high throughout.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at latency 1. REM of the same -> 0. DIVU 7 / 0 -> 0xFFFFFFFF. REMU 7 / 0 -> 7.
- Backpressure: OUT_READY=0 for 4 cycles after an ADD result -> ALU_OUT stable, IN_READY=0. Raise OUT_READY with IN_VALID held -> the next result replaces it on the same edge.
- Signed division DIV -7 / 2 -> 0xFFFFFFFD and REM -7 / 2 -> 0xFFFFFFFF, each after 33 edges.
